// File: rtl/ymz_pcm_bank_router.sv
// ymz_pcm_bank_router
// Routes YMZ280B-style PCM sample fetches to one of NBANKS SDRAM ROM slots.
// The flat sample address is split into a bank index and an in-bank offset.
// The selected slot's chip select is held until the slot reports data-ready.
// The returned byte is registered and also kept in a one-entry read cache.
// Two kinds of fetch never touch a slot:
//   - out-of-range fetches return zero;
//   - fetches that hit the cache return the cached byte.
// A fetch that never completes is abandoned after TMO cycles and sets a sticky
// error flag.
//
// Ports
//   CLK96      in   system clock, rising edge
//   RESET96_N  in   asynchronous active-low reset
//   ROM_RD     in   fetch strobe, accepted only in IDLE
//   ROM_ADDR   in   flat byte address, sampled with ROM_RD
//   ROM_DOUT   out  returned byte, held between ROM_VALID pulses
//   ROM_VALID  out  one-cycle pulse, ROM_DOUT carries the fetched byte
//   ROM_BUSY   out  high from the accept cycle until ROM_VALID has pulsed
//   FLUSH      in   invalidate the read cache
//   BANK_CS    out  one-hot slot chip select
//   BANK_ADDR  out  per-slot offset, slot i at [i*BANK_AW +: BANK_AW]
//   BANK_OK    in   per-slot data-ready
//   BANK_DOUT  in   per-slot data, slot i at [i*DW +: DW]
//   TMO_ERR    out  sticky fetch-timeout flag, cleared only by reset
//
// State   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for ROM_RD; decodes hit / out-of-range / miss
// S_FETCH | chip select held on one slot, waiting for its OK or timeout
// S_RESP  | ROM_VALID pulse; ROM_DOUT already holds the result

module ymz_pcm_bank_router #(
    parameter int NBANKS  = 3,
    parameter int BANK_AW = 22,
    parameter int AW      = 24,
    parameter int DW      = 8,
    parameter int TMO     = 255
) (
    input  logic                      CLK96,
    input  logic                      RESET96_N,
    input  logic                      ROM_RD,
    input  logic [AW-1:0]             ROM_ADDR,
    output logic [DW-1:0]             ROM_DOUT,
    output logic                      ROM_VALID,
    output logic                      ROM_BUSY,
    input  logic                      FLUSH,
    output logic [NBANKS-1:0]         BANK_CS,
    output logic [NBANKS*BANK_AW-1:0] BANK_ADDR,
    input  logic [NBANKS-1:0]         BANK_OK,
    input  logic [NBANKS*DW-1:0]      BANK_DOUT,
    output logic                      TMO_ERR
);

    localparam int BW = (AW > BANK_AW) ? AW - BANK_AW : 1;
    localparam int SW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

    // The down-counter starts at TMO-1 in the first CS cycle.
    // Reaching zero therefore marks the TMO-th CS cycle.
    localparam logic [7:0] TMO_LOAD = 8'(TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_RESP
    } state_t;

    state_t                    state_q;
    state_t                    state_d;

    logic [BW-1:0]             req_bank;
    logic [BANK_AW-1:0]        req_off;
    logic                      req_oor;
    logic                      req_hit;

    logic [AW-1:0]             addr_q;
    logic [SW-1:0]             bank_q;
    logic                      first_q;
    logic [7:0]                tmr_q;
    logic [DW-1:0]             rom_dout_q;
    logic                      tmo_err_q;
    logic [NBANKS*BANK_AW-1:0] bank_addr_q;

    logic                      cache_vld_q;
    logic [AW-1:0]             cache_tag_q;
    logic [DW-1:0]             cache_data_q;

    logic                      sel_ok;
    logic [DW-1:0]             sel_dout;
    logic                      accept;
    logic                      capture;
    logic                      timeout;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    generate
        if (AW > BANK_AW) begin : g_bank
            assign req_bank = ROM_ADDR[AW-1:BANK_AW];
        end else begin : g_nobank
            assign req_bank = '0;
        end
    endgenerate

    assign req_off = ROM_ADDR[BANK_AW-1:0];
    assign req_oor = (32'(req_bank) >= 32'(NBANKS));
    assign req_hit = cache_vld_q && (cache_tag_q == ROM_ADDR);

    // Slot currently being fetched
    always_comb begin
        sel_ok   = 1'b0;
        sel_dout = '0;
        for (int i = 0; i < NBANKS; i++) begin
            if (bank_q == SW'(i)) begin
                sel_ok   = BANK_OK[i];
                sel_dout = BANK_DOUT[i*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // CS, BUSY and VALID are decoded from the state register.
    // A reset therefore drops CS immediately, without waiting for a clock.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        ROM_VALID = 1'b0;
        ROM_BUSY  = 1'b0;
        BANK_CS   = '0;
        case (state_q)
            S_IDLE: begin
                if (ROM_RD) begin
                    accept  = 1'b1;
                    state_d = (req_hit || req_oor) ? S_RESP : S_FETCH;
                end
            end
            S_FETCH: begin
                ROM_BUSY = 1'b1;
                for (int i = 0; i < NBANKS; i++) begin
                    BANK_CS[i] = (bank_q == SW'(i));
                end
                // An OK seen in the first CS cycle may be left over from the
                // slot's previous address, so it is not trusted.
                if (!first_q && sel_ok) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end else if (tmr_q == 8'd0) begin
                    timeout = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                ROM_BUSY  = 1'b1;
                ROM_VALID = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, timer, result, per-slot offsets, cache
    // ------------------------------------------------------------------
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            addr_q       <= '0;
            bank_q       <= '0;
            first_q      <= 1'b0;
            tmr_q        <= '0;
            rom_dout_q   <= '0;
            tmo_err_q    <= 1'b0;
            bank_addr_q  <= '0;
            cache_vld_q  <= 1'b0;
            cache_tag_q  <= '0;
            cache_data_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= ROM_ADDR;
                bank_q <= req_bank[SW-1:0];
                if (req_hit) begin
                    rom_dout_q <= cache_data_q;
                end else if (req_oor) begin
                    rom_dout_q <= '0;
                end else begin
                    first_q <= 1'b1;
                    tmr_q   <= TMO_LOAD;
                    // Only the addressed slot's offset changes.
                    // Idle slots keep theirs, so they do not refetch.
                    for (int i = 0; i < NBANKS; i++) begin
                        if (req_bank == BW'(i)) begin
                            bank_addr_q[i*BANK_AW +: BANK_AW] <= req_off;
                        end
                    end
                end
            end

            if (state_q == S_FETCH) begin
                first_q <= 1'b0;
                if (tmr_q != 8'd0) begin
                    tmr_q <= tmr_q - 8'd1;
                end
            end

            if (capture) begin
                rom_dout_q   <= sel_dout;
                cache_tag_q  <= addr_q;
                cache_data_q <= sel_dout;
                cache_vld_q  <= 1'b1;
            end

            if (timeout) begin
                rom_dout_q <= '0;
                tmo_err_q  <= 1'b1;
            end

            // FLUSH is applied last: a capture in the same cycle still
            // returns its byte but leaves the cache invalid.
            if (FLUSH) begin
                cache_vld_q <= 1'b0;
            end
        end
    end

    assign ROM_DOUT  = rom_dout_q;
    assign BANK_ADDR = bank_addr_q;
    assign TMO_ERR   = tmo_err_q;

endmodule

// File: tb/tb_ymz_pcm_bank_router.sv
// Testbench for ymz_pcm_bank_router with default parameters
// (3 banks, 22-bit bank offset, 24-bit flat address, 8-bit data, TMO 255).
// A table of fetch transactions is followed by hand-written sequences:
// stale OK, ignored ROM_RD while busy, timeout, and reset mid-fetch.

module tb_ymz_pcm_bank_router;

    logic        clk96;
    logic        reset96_n;
    logic        rom_rd;
    logic [23:0] rom_addr;
    logic [7:0]  rom_dout;
    logic        rom_valid;
    logic        rom_busy;
    logic        flush;
    logic [2:0]  bank_cs;
    logic [65:0] bank_addr;
    logic [2:0]  bank_ok;
    logic [23:0] bank_dout;
    logic        tmo_err;

    int n_vec = 0;
    int n_err = 0;

    ymz_pcm_bank_router dut (
        .CLK96     (clk96),
        .RESET96_N (reset96_n),
        .ROM_RD    (rom_rd),
        .ROM_ADDR  (rom_addr),
        .ROM_DOUT  (rom_dout),
        .ROM_VALID (rom_valid),
        .ROM_BUSY  (rom_busy),
        .FLUSH     (flush),
        .BANK_CS   (bank_cs),
        .BANK_ADDR (bank_addr),
        .BANK_OK   (bank_ok),
        .BANK_DOUT (bank_dout),
        .TMO_ERR   (tmo_err)
    );

    initial clk96 = 1'b0;
    always #5 clk96 = ~clk96;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    typedef struct {
        logic [23:0] addr;
        int          ok_at;     // cycle after accept from which the bank OK is high
        logic [7:0]  byte_v;    // byte presented by the addressed bank
        logic        flush_pre; // pulse FLUSH in IDLE before the request
        int          exp_lat;   // accept -> ROM_VALID in cycles
        logic [7:0]  exp_dout;
        logic [2:0]  exp_cs;
    } txn_t;

    txn_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // The addressed bank gets the wanted byte; the others get its complement.
    function automatic logic [23:0] fill(input logic [23:0] a, input logic [7:0] b);
        logic [23:0] f;
        int t;
        t = int'(a[23:22]);
        for (int i = 0; i < 3; i++) f[i*8 +: 8] = (i == t) ? b : ~b;
        return f;
    endfunction

    function automatic logic [2:0] okmask(input logic [23:0] a);
        logic [1:0] t;
        t = a[23:22];
        return (t < 2'd3) ? (3'b001 << t) : 3'b000;
    endfunction

    task automatic run_txn(input int idx, input txn_t t);
        int k;
        bit got;
        bit cs_bad;
        logic [1:0] tb_bank;
        tb_bank = t.addr[23:22];
        if (t.flush_pre) begin
            flush = 1'b1;
            @(posedge clk96); #1;
            flush = 1'b0;
        end
        rom_addr  = t.addr;
        rom_rd    = 1'b1;
        bank_dout = fill(t.addr, t.byte_v);
        bank_ok   = 3'b000;
        @(posedge clk96); #1;
        rom_rd = 1'b0;
        k      = 1;
        got    = 1'b0;
        cs_bad = 1'b0;
        while (k <= 400 && !got) begin
            if (rom_valid) begin
                got = 1'b1;
            end else begin
                if (bank_cs !== t.exp_cs) cs_bad = 1'b1;
                if (k == 1 && t.exp_cs != 3'b000)
                    chk($sformatf("t%0d_bank_addr", idx),
                        32'(bank_addr[int'(tb_bank)*22 +: 22]), 32'(t.addr[21:0]));
                bank_ok = (k >= t.ok_at) ? okmask(t.addr) : 3'b000;
                @(posedge clk96); #1;
                k++;
            end
        end
        chk($sformatf("t%0d_valid_seen", idx), 32'(got), 32'd1);
        chk($sformatf("t%0d_latency", idx), 32'(k), 32'(t.exp_lat));
        chk($sformatf("t%0d_dout", idx), 32'(rom_dout), 32'(t.exp_dout));
        chk($sformatf("t%0d_cs_during", idx), 32'(cs_bad), 32'd0);
        chk($sformatf("t%0d_cs_at_valid", idx), 32'(bank_cs), 32'd0);
        chk($sformatf("t%0d_busy_at_valid", idx), 32'(rom_busy), 32'd1);
        bank_ok = 3'b000;
        @(posedge clk96); #1;
        chk($sformatf("t%0d_valid_single", idx), 32'(rom_valid), 32'd0);
        chk($sformatf("t%0d_busy_after", idx), 32'(rom_busy), 32'd0);
        chk($sformatf("t%0d_dout_hold", idx), 32'(rom_dout), 32'(t.exp_dout));
    endtask

    initial begin
        int nvalid;
        int vk;
        int ncs;
        int k;
        bit other_cs;

        //            addr       ok_at byte   flush lat dout   cs
        tbl[0] = '{24'h412345,   3, 8'hA5, 1'b0, 4, 8'hA5, 3'b010}; // miss
        tbl[1] = '{24'h412345,  99, 8'h00, 1'b0, 1, 8'hA5, 3'b000}; // hit
        tbl[2] = '{24'hC00010,  99, 8'h77, 1'b0, 1, 8'h00, 3'b000}; // out of range
        tbl[3] = '{24'h412345,   2, 8'h3C, 1'b1, 3, 8'h3C, 3'b010}; // refetch after FLUSH
        tbl[4] = '{24'h412345,  99, 8'h00, 1'b0, 1, 8'h3C, 3'b000}; // hit new byte
        tbl[5] = '{24'h3FFFFF,   1, 8'h11, 1'b0, 3, 8'h11, 3'b001}; // last byte bank 0
        tbl[6] = '{24'hBFFFFF,   5, 8'hE7, 1'b0, 6, 8'hE7, 3'b100}; // last byte bank 2
        tbl[7] = '{24'h412345,   1, 8'h99, 1'b0, 3, 8'h99, 3'b010}; // evicted -> miss
        tbl[8] = '{24'hFFFFFF,  99, 8'h55, 1'b0, 1, 8'h00, 3'b000}; // all-ones is OOR
        tbl[9] = '{24'h412345,  99, 8'h00, 1'b0, 1, 8'h99, 3'b000}; // hit

        reset96_n = 1'b0;
        rom_rd    = 1'b0;
        rom_addr  = '0;
        flush     = 1'b0;
        bank_ok   = '0;
        bank_dout = '0;
        repeat (3) @(posedge clk96);
        #1;
        chk("rst_dout", 32'(rom_dout), 32'd0);
        chk("rst_valid", 32'(rom_valid), 32'd0);
        chk("rst_busy", 32'(rom_busy), 32'd0);
        chk("rst_cs", 32'(bank_cs), 32'd0);
        chk("rst_bank_addr", 32'(|bank_addr), 32'd0);
        chk("rst_tmo_err", 32'(tmo_err), 32'd0);
        reset96_n = 1'b1;
        @(posedge clk96); #1;

        for (int i = 0; i < 10; i++) run_txn(i, tbl[i]);

        chk("tmo_err_clear_after_oor", 32'(tmo_err), 32'd0);
        chk("bank0_addr_held", 32'(bank_addr[0 +: 22]), 32'h3FFFFF);
        chk("bank1_addr_held", 32'(bank_addr[22 +: 22]), 32'h012345);
        chk("bank2_addr_held", 32'(bank_addr[44 +: 22]), 32'h3FFFFF);

        // Stale OK: bank 0 OK already high before the request.
        bank_dout = fill(24'h000100, 8'h5C);
        bank_ok   = 3'b001;
        rom_addr  = 24'h000100;
        rom_rd    = 1'b1;
        @(posedge clk96); #1;
        rom_rd = 1'b0;
        chk("stale_cs_c1", 32'(bank_cs), 32'b001);
        chk("stale_valid_c1", 32'(rom_valid), 32'd0);
        @(posedge clk96); #1;
        chk("stale_cs_c2", 32'(bank_cs), 32'b001);
        chk("stale_valid_c2", 32'(rom_valid), 32'd0);
        @(posedge clk96); #1;
        chk("stale_valid_c3", 32'(rom_valid), 32'd1);
        chk("stale_dout", 32'(rom_dout), 32'h5C);
        chk("stale_cs_c3", 32'(bank_cs), 32'd0);
        bank_ok = 3'b000;
        @(posedge clk96); #1;

        // ROM_RD pulsed during FETCH and RESP must be ignored.
        bank_dout = fill(24'h412000, 8'h6D);
        rom_addr  = 24'h412000;
        rom_rd    = 1'b1;
        @(posedge clk96); #1;
        nvalid   = 0;
        vk       = 0;
        other_cs = 1'b0;
        rom_addr = 24'h800004;
        for (int kk = 1; kk <= 12; kk++) begin
            if (rom_valid) begin
                nvalid++;
                vk = kk;
            end
            if (bank_cs[0] || bank_cs[2]) other_cs = 1'b1;
            rom_rd  = (kk <= 3 || kk == 5);
            bank_ok = (kk >= 4) ? 3'b010 : 3'b000;
            @(posedge clk96); #1;
        end
        rom_rd  = 1'b0;
        bank_ok = 3'b000;
        chk("busy_ign_valid_count", 32'(nvalid), 32'd1);
        chk("busy_ign_valid_cycle", 32'(vk), 32'd5);
        chk("busy_ign_other_cs", 32'(other_cs), 32'd0);
        chk("busy_ign_dout", 32'(rom_dout), 32'h6D);

        // Timeout: OK stuck low.
        chk("tmo_err_before", 32'(tmo_err), 32'd0);
        bank_dout = fill(24'h000200, 8'h21);
        rom_addr  = 24'h000200;
        rom_rd    = 1'b1;
        @(posedge clk96); #1;
        rom_rd = 1'b0;
        ncs = 0;
        k   = 0;
        while (!rom_valid && k < 400) begin
            if (bank_cs == 3'b001) ncs++;
            @(posedge clk96); #1;
            k++;
        end
        chk("tmo_valid_seen", 32'(rom_valid), 32'd1);
        chk("tmo_cs_cycles", 32'(ncs), 32'd255);
        chk("tmo_dout", 32'(rom_dout), 32'd0);
        chk("tmo_err_set", 32'(tmo_err), 32'd1);
        @(posedge clk96); #1;
        chk("tmo_busy_after", 32'(rom_busy), 32'd0);

        // A timed-out fetch must not have filled the cache.
        run_txn(10, '{24'h000200, 1, 8'h42, 1'b0, 3, 8'h42, 3'b001});
        chk("tmo_err_sticky", 32'(tmo_err), 32'd1);

        // Reset in the middle of a fetch.
        bank_dout = fill(24'h412999, 8'h13);
        rom_addr  = 24'h412999;
        rom_rd    = 1'b1;
        @(posedge clk96); #1;
        rom_rd = 1'b0;
        @(posedge clk96); #1;
        chk("rstmid_cs_before", 32'(bank_cs), 32'b010);
        reset96_n = 1'b0;
        #1;
        chk("rstmid_cs", 32'(bank_cs), 32'd0);
        chk("rstmid_busy", 32'(rom_busy), 32'd0);
        chk("rstmid_valid", 32'(rom_valid), 32'd0);
        chk("rstmid_dout", 32'(rom_dout), 32'd0);
        chk("rstmid_tmo_err", 32'(tmo_err), 32'd0);
        chk("rstmid_bank_addr", 32'(|bank_addr), 32'd0);
        @(posedge clk96); #1;
        reset96_n = 1'b1;
        bank_ok   = 3'b010;
        nvalid    = 0;
        for (int kk = 0; kk < 6; kk++) begin
            if (rom_valid || (bank_cs != 3'b000)) nvalid++;
            @(posedge clk96); #1;
        end
        chk("rstmid_no_activity", 32'(nvalid), 32'd0);
        bank_ok = 3'b000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
